key_event_ctrl: RTL and testbench

- Event controller behind a bank of debounced keys (active-low, one debouncer instance per key, clocked on the same clk).
- Tracks each key through press/hold/release and classifies short vs long presses.
- Arbitrates round-robin between keys for a single shared event FIFO.
- Presents events to the consumer (menu/UI logic) on a valid/ready interface.

---
 rtl/key_evt_pkg.sv | 20 ++
 rtl/key_evt_fsm.sv | 107 ++++++++++
 rtl/key_event_ctrl.sv | 143 ++++++++++++++
 tb/tb_key_event_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared types and constants for the key event controller: event codes,
// per-key FSM state encoding and key-index width helper.
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS     = 2'd0;
    localparam logic [1:0] EVT_REL_SHORT = 2'd1;
    localparam logic [1:0] EVT_LONG      = 2'd2;
    localparam logic [1:0] EVT_REL_LONG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_t;

    function automatic int key_id_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage

// File: rtl/key_evt_fsm.sv
// Single-key tracker: edge detection on the registered key level, press/hold
// classification with a hold counter, and a one-deep pending event slot.
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_q,
    input  logic       grant,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       drop
);

    localparam int CNT_W = (LONG_PRESS_CYC > 1) ? $clog2(LONG_PRESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(LONG_PRESS_CYC - 1);

    key_state_t       state_r;
    key_state_t       state_next_s;
    logic             key_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             pend_valid_r;
    logic [1:0]       pend_type_r;
    logic             fall_s;
    logic             rise_s;
    logic             raise_s;
    logic [1:0]       raise_type_s;
    logic             slot_load_s;

    assign fall_s      = key_prev_r & ~key_q;
    assign rise_s      = ~key_prev_r & key_q;
    assign slot_load_s = raise_s & (~pend_valid_r | grant);
    assign drop        = raise_s & pend_valid_r & ~grant;
    assign pend_valid  = pend_valid_r;
    assign pend_type   = pend_type_r;

    // Next-state, counter and event-raise decode; a release always beats the long-press terminal.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        raise_s      = 1'b0;
        raise_type_s = EVT_PRESS;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = PRESSED;
                    cnt_next_s   = {CNT_W{1'b0}};
                    raise_s      = 1'b1;
                    raise_type_s = EVT_PRESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESSED: begin
                if (rise_s) begin
                    state_next_s = IDLE;
                    raise_s      = 1'b1;
                    raise_type_s = EVT_REL_SHORT;
                end else if (cnt_r == CNT_TERM) begin
                    state_next_s = HELD;
                    raise_s      = 1'b1;
                    raise_type_s = EVT_LONG;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            HELD: begin
                if (rise_s) begin
                    state_next_s = IDLE;
                    raise_s      = 1'b1;
                    raise_type_s = EVT_REL_LONG;
                end else begin
                    state_next_s = HELD;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, edge history and pending slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            key_prev_r   <= 1'b1;
            pend_valid_r <= 1'b0;
            pend_type_r  <= EVT_PRESS;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            key_prev_r <= key_q;
            if (slot_load_s) begin
                pend_valid_r <= 1'b1;
                pend_type_r  <= raise_type_s;
            end else if (grant) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key trackers feed a round-robin arbiter that
// loads a first-word-fall-through event FIFO read over valid/ready.
module key_event_ctrl
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int LONG_PRESS_CYC = 25_000_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_KEYS-1:0]               deb_key_n,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [key_id_w(NUM_KEYS)-1:0]     evt_key_id,
    output logic [1:0]                        evt_type,
    output logic                              evt_ovf,
    input  logic                              ovf_clr
);

    localparam int KEY_ID_W = key_id_w(NUM_KEYS);
    localparam int ENT_W    = KEY_ID_W + 2;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W   = PTR_W + 1;

    logic [NUM_KEYS-1:0] key_q_r;
    logic [NUM_KEYS-1:0] pend_valid_s;
    logic [1:0]          pend_type_s [NUM_KEYS];
    logic [NUM_KEYS-1:0] drop_s;
    logic [NUM_KEYS-1:0] grant_s;
    logic [KEY_ID_W-1:0] rr_ptr_r;
    logic [KEY_ID_W-1:0] rr_next_s;
    logic [KEY_ID_W-1:0] win_id_s;
    logic [1:0]          win_type_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic [ENT_W-1:0]    wr_data_s;
    logic [ENT_W-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    rd_next_s;
    logic [FCNT_W-1:0]   fifo_cnt_r;
    logic [FCNT_W-1:0]   cnt_next_s;
    logic [ENT_W-1:0]    head_next_s;
    logic                evt_valid_r;
    logic [ENT_W-1:0]    head_r;
    logic                evt_ovf_r;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_evt_fsm #(
            .LONG_PRESS_CYC(LONG_PRESS_CYC)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .key_q     (key_q_r[i]),
            .grant     (grant_s[i]),
            .pend_valid(pend_valid_s[i]),
            .pend_type (pend_type_s[i]),
            .drop      (drop_s[i])
        );
    end

    assign full_s    = (fifo_cnt_r == FCNT_W'(FIFO_DEPTH));
    assign pop_s     = evt_valid_r & evt_ready;
    assign wr_data_s = {win_id_s, win_type_s};
    assign rd_next_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;

    // Round-robin pick: scan from the far end so the slot nearest rr_ptr_r wins.
    always_comb begin
        int idx_v;
        logic hit_v;
        grant_s    = {NUM_KEYS{1'b0}};
        win_id_s   = {KEY_ID_W{1'b0}};
        win_type_s = EVT_PRESS;
        push_s     = 1'b0;
        for (int off = NUM_KEYS - 1; off >= 0; off--) begin
            idx_v      = (int'(rr_ptr_r) + off) % NUM_KEYS;
            hit_v      = pend_valid_s[idx_v] & ~full_s;
            grant_s    = hit_v ? (NUM_KEYS'(1) << idx_v) : grant_s;
            win_id_s   = hit_v ? KEY_ID_W'(idx_v) : win_id_s;
            win_type_s = hit_v ? pend_type_s[idx_v] : win_type_s;
            push_s     = push_s | hit_v;
        end
        rr_next_s = (int'(win_id_s) == NUM_KEYS - 1) ? {KEY_ID_W{1'b0}} : win_id_s + KEY_ID_W'(1);
    end

    // FIFO occupancy and next head; a head landing on the slot being written takes the write data.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = fifo_cnt_r + FCNT_W'(1);
            2'b01:   cnt_next_s = fifo_cnt_r - FCNT_W'(1);
            default: cnt_next_s = fifo_cnt_r;
        endcase
        if (cnt_next_s == {FCNT_W{1'b0}}) begin
            head_next_s = {ENT_W{1'b0}};
        end else if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = wr_data_s;
        end else begin
            head_next_s = fifo_mem_r[rd_next_s];
        end
    end

    // FIFO storage array (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // Input sampling, arbiter pointer, FIFO pointers, registered head and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q_r     <= {NUM_KEYS{1'b1}};
            rr_ptr_r    <= {KEY_ID_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {FCNT_W{1'b0}};
            evt_valid_r <= 1'b0;
            head_r      <= {ENT_W{1'b0}};
            evt_ovf_r   <= 1'b0;
        end else begin
            key_q_r     <= deb_key_n;
            rr_ptr_r    <= push_s ? rr_next_s : rr_ptr_r;
            wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            rd_ptr_r    <= rd_next_s;
            fifo_cnt_r  <= cnt_next_s;
            evt_valid_r <= (cnt_next_s != {FCNT_W{1'b0}});
            head_r      <= head_next_s;
            if (|drop_s) begin
                evt_ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf_r <= 1'b0;
            end
        end
    end

    assign evt_valid  = evt_valid_r;
    assign evt_key_id = head_r[ENT_W-1:2];
    assign evt_type   = head_r[1:0];
    assign evt_ovf    = evt_ovf_r;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: expected events are queued as keys are
// driven and compared in order as the consumer accepts them.
module tb_key_event_ctrl;
    import key_evt_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] deb_key_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key_id;
    logic [1:0] evt_type;
    logic       evt_ovf;
    logic       ovf_clr;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [3:0] exp_q[$];
    int         pop_cyc_q[$];
    logic [3:0] exp_v;
    int         base;
    int         c0;

    key_event_ctrl #(
        .NUM_KEYS(4),
        .LONG_PRESS_CYC(100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .deb_key_n (deb_key_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key_id(evt_key_id),
        .evt_type  (evt_type),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] ev(input logic [1:0] id, input logic [1:0] t);
        return {id, t};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        tick(3);
    endtask

    // Consumer-side scoreboard: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (evt_valid && evt_ready) begin
            check("evt_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check("evt_id_type", {evt_key_id, evt_type}, exp_v);
            end
            pop_cyc_q.push_back(cyc);
        end
    end

    initial begin
        rst = 1'b1; deb_key_n = 4'b1111; evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        check("rst_valid", evt_valid, 0);
        check("rst_key_id", evt_key_id, 0);
        check("rst_type", evt_type, 0);
        check("rst_ovf", evt_ovf, 0);
        rst = 1'b0;
        tick(2);

        // Short press on key 2 with latency and gap checks
        base = pop_cyc_q.size(); c0 = cyc;
        deb_key_n[2] = 1'b0; exp_q.push_back(ev(2'd2, EVT_PRESS));
        tick(2); check("t1_valid_early", evt_valid, 0);
        tick(1); check("t1_valid_on_time", evt_valid, 1);
        tick(37);
        deb_key_n[2] = 1'b1; exp_q.push_back(ev(2'd2, EVT_REL_SHORT));
        drain("t1");
        check("t1_press_latency", pop_cyc_q[base] - c0, 3);
        check("t1_rel_gap", pop_cyc_q[base+1] - pop_cyc_q[base], 40);
        check("t1_event_count", pop_cyc_q.size() - base, 2);

        // Long press on key 1
        base = pop_cyc_q.size(); c0 = cyc;
        deb_key_n[1] = 1'b0;
        exp_q.push_back(ev(2'd1, EVT_PRESS)); exp_q.push_back(ev(2'd1, EVT_LONG));
        tick(250);
        deb_key_n[1] = 1'b1; exp_q.push_back(ev(2'd1, EVT_REL_LONG));
        drain("t2");
        check("t2_long_gap", pop_cyc_q[base+1] - pop_cyc_q[base], 100);
        check("t2_rel_latency", pop_cyc_q[base+2] - (c0 + 250), 3);
        check("t2_event_count", pop_cyc_q.size() - base, 3);

        // Round-robin ordering from pointer 0
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        base = pop_cyc_q.size();
        deb_key_n = 4'b0000;
        for (int k = 0; k < 4; k++) exp_q.push_back(ev(2'(k), EVT_PRESS));
        drain("t3_all");
        check("t3_back_to_back", pop_cyc_q[base+3] - pop_cyc_q[base], 3);
        deb_key_n = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(ev(2'(k), EVT_REL_SHORT));
        drain("t3_rel");
        deb_key_n = 4'b0110;
        exp_q.push_back(ev(2'd0, EVT_PRESS)); exp_q.push_back(ev(2'd3, EVT_PRESS));
        drain("t3_pair");
        deb_key_n = 4'b1111;
        exp_q.push_back(ev(2'd0, EVT_REL_SHORT)); exp_q.push_back(ev(2'd3, EVT_REL_SHORT));
        drain("t3_pair_rel");

        // Back-pressure: FIFO fills, slots retain, extra event overflows
        evt_ready = 1'b0;
        deb_key_n = 4'b0001;
        for (int k = 1; k < 4; k++) exp_q.push_back(ev(2'(k), EVT_PRESS));
        tick(10);
        deb_key_n = 4'b1111;
        for (int k = 1; k < 4; k++) exp_q.push_back(ev(2'(k), EVT_REL_SHORT));
        tick(10);
        check("t4_valid_full", evt_valid, 1);
        check("t4_head_id", evt_key_id, 1);
        check("t4_head_type", evt_type, EVT_PRESS);
        check("t4_ovf_clear", evt_ovf, 0);
        deb_key_n[2] = 1'b0; tick(5); deb_key_n[2] = 1'b1; tick(6);
        check("t4_ovf_set", evt_ovf, 1);
        check("t4_head_stable", {evt_key_id, evt_type}, ev(2'd1, EVT_PRESS));
        evt_ready = 1'b1;
        drain("t4");
        check("t4_ovf_sticky", evt_ovf, 1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("t4_ovf_cleared", evt_ovf, 0);

        // Key held through reset, then reset while another key is HELD
        rst = 1'b1; deb_key_n[0] = 1'b0;
        tick(3);
        check("t5_rst_valid", evt_valid, 0);
        base = pop_cyc_q.size();
        rst = 1'b0; exp_q.push_back(ev(2'd0, EVT_PRESS));
        drain("t5_press");
        check("t5_single_press", pop_cyc_q.size() - base, 1);
        deb_key_n[0] = 1'b1; exp_q.push_back(ev(2'd0, EVT_REL_SHORT));
        drain("t5_rel");
        deb_key_n[1] = 1'b0;
        exp_q.push_back(ev(2'd1, EVT_PRESS)); exp_q.push_back(ev(2'd1, EVT_LONG));
        drain("t5_hold");
        rst = 1'b1; tick(1);
        check("t5_midhold_valid", evt_valid, 0);
        check("t5_midhold_ovf", evt_ovf, 0);
        deb_key_n[1] = 1'b1; tick(2);
        rst = 1'b0;
        base = pop_cyc_q.size();
        tick(20);
        check("t5_no_release_evt", pop_cyc_q.size() - base, 0);
        check("t5_idle_valid", evt_valid, 0);

        // Release exactly at the long-press terminal, then one cycle later
        base = pop_cyc_q.size();
        deb_key_n[3] = 1'b0;
        exp_q.push_back(ev(2'd3, EVT_PRESS)); exp_q.push_back(ev(2'd3, EVT_REL_SHORT));
        tick(100);
        deb_key_n[3] = 1'b1;
        drain("t6_term");
        check("t6_term_count", pop_cyc_q.size() - base, 2);
        base = pop_cyc_q.size();
        deb_key_n[3] = 1'b0;
        exp_q.push_back(ev(2'd3, EVT_PRESS)); exp_q.push_back(ev(2'd3, EVT_LONG));
        exp_q.push_back(ev(2'd3, EVT_REL_LONG));
        tick(101);
        deb_key_n[3] = 1'b1;
        drain("t6_past_term");
        check("t6_past_term_count", pop_cyc_q.size() - base, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
